// File: rtl/inc_width_converter_16to32.sv
// Packs pairs of narrow source words into one double-width word, first word in the upper half.
// One holding register plus one output register lets the source keep streaming while a packed word waits.
module inc_width_converter_16to32 #(
    parameter int InputDataWidth  = 16,
    parameter int OutputDataWidth = 32
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iSrcDataValid,
    input  logic [InputDataWidth-1:0]  iSrcData,
    output logic                       oConverterReady,
    output logic                       oConvertedDataValid,
    output logic [OutputDataWidth-1:0] oConvertedData,
    input  logic                       iDstReady,
    output logic [1:0]                 oDbgState
);

    // Handshake: a word moves on a rising edge only when valid and ready are both 1 in that cycle;
    // ready and valid are registered here, so neither depends combinationally on the other side.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_HALF      = 2'd1,
        ST_FULL      = 2'd2,
        ST_FULL_HALF = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [InputDataWidth-1:0]    hold_q, hold_d;
    logic [OutputDataWidth-1:0]   out_q, out_d;
    logic                         valid_q, valid_d;
    logic                         ready_q, ready_d;
    logic                         accept_in;
    logic                         accept_out;

    assign accept_in  = iSrcDataValid & ready_q;
    assign accept_out = valid_q & iDstReady;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        out_d   = out_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_in) begin
                    state_d = ST_HALF;
                    hold_d  = iSrcData;
                end
            end
            ST_HALF: begin
                if (accept_in) begin
                    state_d = ST_FULL;
                    out_d   = {hold_q, iSrcData};
                end
            end
            ST_FULL: begin
                // A new first half can be captured while the packed word is still waiting.
                if (accept_in) begin
                    hold_d  = iSrcData;
                    state_d = accept_out ? ST_HALF : ST_FULL_HALF;
                end else if (accept_out) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL_HALF: begin
                if (accept_out) begin
                    state_d = ST_HALF;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        valid_d = (state_d == ST_FULL) || (state_d == ST_FULL_HALF);
        ready_d = (state_d != ST_FULL_HALF);
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign oConverterReady     = ready_q;
    assign oConvertedDataValid = valid_q;
    assign oConvertedData      = out_q;
    assign oDbgState           = state_q;

endmodule

// File: tb/tb_inc_width_converter_16to32.sv
// Bench for inc_width_converter_16to32: directed scenarios plus a long random run against a
// queue-of-halfwords reference model (word = first two pending halfwords, capacity three).
module tb_inc_width_converter_16to32;

  logic        clk;
  logic        rst_n;
  logic        src_valid;
  logic [15:0] src_data;
  logic        conv_ready;
  logic        conv_valid;
  logic [31:0] conv_data;
  logic        dst_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [15:0] hw_q[$];
  logic [31:0] out_log[$];
  logic [31:0] exp_q[$];
  bit          in_reset = 1'b1;

  inc_width_converter_16to32 #(
    .InputDataWidth(16),
    .OutputDataWidth(32)
  ) dut (
    .iClock(clk),
    .iReset(rst_n),
    .iSrcDataValid(src_valid),
    .iSrcData(src_data),
    .oConverterReady(conv_ready),
    .oConvertedDataValid(conv_valid),
    .oConvertedData(conv_data),
    .iDstReady(dst_ready),
    .oDbgState(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  function automatic bit exp_ready();
    return !in_reset && (hw_q.size() < 3);
  endfunction

  function automatic bit exp_valid();
    return !in_reset && (hw_q.size() >= 2);
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic sv, input logic [15:0] d, input logic dr,
                      input logic rn, output bit accepted);
    bit ain, aout;
    logic [31:0] word;
    checks++;
    if (conv_ready !== exp_ready()) begin
      failures++;
      $display("FAIL step_ready: got %b want %b (t=%0t)", conv_ready, exp_ready(), $time);
    end
    checks++;
    if (conv_valid !== exp_valid()) begin
      failures++;
      $display("FAIL step_valid: got %b want %b (t=%0t)", conv_valid, exp_valid(), $time);
    end
    if (exp_valid()) begin
      checks++;
      if (conv_data !== {hw_q[0], hw_q[1]}) begin
        failures++;
        $display("FAIL step_data: got %h want %h (t=%0t)", conv_data, {hw_q[0], hw_q[1]}, $time);
      end
    end
    src_valid = sv;
    src_data  = d;
    dst_ready = dr;
    rst_n     = rn;
    ain  = rn && sv && exp_ready();
    aout = rn && dr && exp_valid();
    @(posedge clk);
    if (!rn) begin
      hw_q.delete();
      in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      if (aout) begin
        word = {hw_q[0], hw_q[1]};
        void'(hw_q.pop_front());
        void'(hw_q.pop_front());
        out_log.push_back(word);
      end
      if (ain) hw_q.push_back(d);
    end
    accepted = ain;
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    bit acc;
    step(1'b0, 16'h0, dr, 1'b1, acc);
  endtask

  // Offer a halfword until accepted, bounded.
  task automatic send(input logic [15:0] d, input logic dr);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, d, dr, 1'b1, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout: halfword %h not accepted within 20 cycles", d);
    end
  endtask

  task automatic check_log(input string name);
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d words want %0d", name, out_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s_word%0d: got %h want %h", name, i, out_log[i], exp_q[i]);
        end
      end
    end
    out_log.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b0, 16'h0, 1'b0, 1'b0, acc);
    step(1'b0, 16'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_valid = 1'b0;
    src_data = 16'h0;
    dst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (conv_ready !== 1'b0 || conv_valid !== 1'b0 || conv_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h want 0 0 00000000",
               conv_ready, conv_valid, conv_data);
    end
    in_reset = 1'b1;
    idle(1'b0);
    checks++;
    if (conv_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", conv_ready);
    end
  endtask

  task automatic test_basic();
    send(16'hDEAD, 1'b1);
    send(16'hBEEF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    exp_q.push_back(32'hDEADBEEF);
    check_log("basic");
  endtask

  task automatic test_streaming();
    bit acc;
    int not_acc = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b1, acc);
      if (!acc) not_acc++;
    end
    idle(1'b1);
    idle(1'b1);
    checks++;
    if (not_acc != 0) begin
      failures++;
      $display("FAIL stream_bubbles: got %0d refused halfwords want 0", not_acc);
    end
    exp_q = '{32'h00010002, 32'h00030004, 32'h00050006, 32'h00070008};
    check_log("stream");
  endtask

  task automatic test_backpressure();
    bit acc;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    repeat (3) idle(1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b1, acc);
    checks++;
    if (acc || conv_ready !== 1'b0 || conv_data !== 32'h11112222) begin
      failures++;
      $display("FAIL bp_stall: accepted=%b ready=%b data=%h want 0 0 11112222",
               acc, conv_ready, conv_data);
    end
    send(16'h4444, 1'b1);
    idle(1'b1);
    idle(1'b1);
    exp_q = '{32'h11112222, 32'h33334444};
    check_log("bp");
  endtask

  task automatic test_gap();
    send(16'hAAAA, 1'b1);
    repeat (5) idle(1'b1);
    send(16'h5555, 1'b1);
    idle(1'b1);
    idle(1'b1);
    exp_q.push_back(32'hAAAA5555);
    check_log("gap");
  endtask

  task automatic test_reset_mid();
    bit acc;
    send(16'h1234, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, acc);
    send(16'h5678, 1'b1);
    send(16'h9ABC, 1'b1);
    idle(1'b1);
    idle(1'b1);
    exp_q.push_back(32'h56789ABC);
    check_log("reset_mid");
  endtask

  task automatic test_random();
    bit acc;
    logic [15:0] sent[$];
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      step(logic'($urandom_range(0, 3) != 0), d, logic'($urandom_range(0, 2) != 0), 1'b1, acc);
      if (acc) sent.push_back(d);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    for (int i = 0; i + 1 < sent.size(); i += 2) exp_q.push_back({sent[i], sent[i+1]});
    check_log("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_gap();
    test_reset_mid();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inc_width_converter_16to32.md
INC_WIDTH_CONVERTER_16TO32 -- requirements
Module: inc_width_converter_16to32

Interface
REQ-001 Parameter InputDataWidth, default 16, width of the narrow source word.
REQ-002 Parameter OutputDataWidth, default 32, width of the packed destination word; SHALL equal 2 x InputDataWidth (other ratios unsupported).
REQ-003 iClock  input  1  sole clock; all state changes on its rising edge.
REQ-004 iReset  input  1  synchronous, active-low reset: low at a rising edge of iClock resets the block.
REQ-005 iSrcDataValid  input  1  source word on iSrcData is valid.
REQ-006 iSrcData  input  InputDataWidth  narrow source word.
REQ-007 oConverterReady  output  1  block accepts a source word this cycle.
REQ-008 oConvertedDataValid  output  1  oConvertedData holds a valid packed word.
REQ-009 oConvertedData  output  OutputDataWidth  packed word.
REQ-010 iDstReady  input  1  destination accepts the packed word this cycle.

Function
REQ-011 Accept event AIN = iSrcDataValid & oConverterReady; output event AOUT = oConvertedDataValid & iDstReady; both evaluated at the same rising edge.
REQ-012 Packing order SHALL be MSB-first: first accepted halfword goes to oConvertedData[31:16], second to [15:0], mirroring the 32-to-16 downsizer emission order.
REQ-013 Storage: one halfword holding register (rHold) and one full-width output register (rOut); no other data storage.
REQ-014 FSM states: Empty (nothing held), Half (rHold valid, rOut empty), Full (rOut valid, rHold empty), FullHalf (rOut valid and rHold valid).
REQ-015 Empty: AIN -> Half, rHold <= iSrcData; else stay.
REQ-016 Half: AIN -> Full, rOut <= {rHold, iSrcData}; else stay, rHold unchanged.
REQ-017 Full: AIN & AOUT -> Half (rHold <= iSrcData); AIN & !AOUT -> FullHalf (rHold <= iSrcData); !AIN & AOUT -> Empty; neither -> stay.
REQ-018 FullHalf: no input accepted; AOUT -> Half (rHold retained); else stay.
REQ-019 oConvertedDataValid SHALL be 1 exactly in Full and FullHalf; registered, no combinational path from any input.
REQ-020 oConverterReady SHALL be registered, 1 in Empty, Half, Full; 0 in FullHalf; no combinational path from iDstReady or iSrcDataValid.
REQ-021 oConvertedData SHALL remain stable while oConvertedDataValid=1 and iDstReady=0.
REQ-022 Latency: packed word visible on the cycle after the second halfword is accepted (1 cycle).
REQ-023 Throughput: with iSrcDataValid and iDstReady held 1, one halfword accepted every cycle, one packed word emitted every 2 cycles, no bubbles.
REQ-024 Source-side stall (iSrcDataValid=0 between halves) SHALL NOT lose or reorder data; Half persists indefinitely.
REQ-025 Unused/illegal state encodings SHALL return to Empty on the next edge.
REQ-026 iSrcData is ignored when AIN=0; iDstReady is ignored when oConvertedDataValid=0.

Reset
REQ-027 While iReset=0 at an edge: state <= Empty, rHold <= 0, rOut <= 0, oConvertedDataValid <= 0, oConverterReady <= 0.
REQ-028 First edge with iReset=1: oConverterReady becomes 1 (state Empty).
REQ-029 Reset mid-operation (Half, Full or FullHalf) SHALL discard all held data; no partial word is emitted afterwards.

Verification
REQ-030 Basic pack: reset, then halfwords 0xDEAD, 0xBEEF on consecutive cycles, iDstReady=1 -> one word 0xDEADBEEF, valid for 1 cycle.
REQ-031 Streaming: 8 consecutive halfwords 0x0001..0x0008, both sides always ready -> words 0x00010002, 0x00030004, 0x00050006, 0x00070008 every 2 cycles, oConverterReady never drops.
REQ-032 Backpressure: iDstReady=0, feed 0x1111, 0x2222, 0x3333 -> 0x11112222 held stable, FullHalf reached, oConverterReady=0 and 0x4444 not accepted; raise iDstReady -> 0x11112222 accepted, then 0x4444 accepted, 0x33334444 emitted.
REQ-033 Source gap: 0xAAAA, then iSrcDataValid=0 for 5 cycles, then 0x5555 -> exactly one word 0xAAAA5555, no valid during gap.
REQ-034 Reset mid-word: accept 0x1234, assert iReset=0 one cycle, then send 0x5678, 0x9ABC -> output 0x56789ABC only; 0x1234 never appears.
REQ-035 Random: random iSrcDataValid/iDstReady, scoreboard compares packed stream to pairs of accepted halfwords; no loss, duplication or reordering over 10,000 cycles.
